// File: rtl/da_z7_reader.sv
// Bit-serial distributed-arithmetic reader for the z7 DCT coefficient.
// Walks four signed samples LSB first, reads the z7 half-ROM once per bit-plane, shift-accumulates.
module da_z7_reader #(
  parameter int                     W    = 16,
  parameter int                     ACCW = 36,
  parameter logic signed [ACCW-1:0] Q0   = '0
) (
  input  logic            clk,
  input  logic            rst,
  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and the data stays stable while valid waits for ready.
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    x0,
  input  logic [W-1:0]    x1,
  input  logic [W-1:0]    x2,
  input  logic [W-1:0]    x3,
  output logic            rom_cs,
  output logic [2:0]      rom_addr,
  input  logic [15:0]     rom_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] z,
  output logic [1:0]      dbg_state
);

  localparam int JW = $clog2(W);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [W-1:0]           sr0_q, sr1_q, sr2_q, sr3_q;
  logic [JW-1:0]          j_q;
  logic signed [ACCW-1:0] acc_q;
  logic [ACCW-1:0]        z_q;

  logic                   load, step, last;
  logic [2:0]             plane_addr;
  logic signed [16:0]     rom_word, term;
  logic signed [ACCW-1:0] term_ext, term_sh, acc_next;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_WAIT;
    else     state_q <= state_d;
  end

  assign last = (j_q == JW'(W - 1));

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rom_cs    = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      // One dead cycle while the ROM still drives zero after reset.
      ST_WAIT: state_d = ST_IDLE;
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        rom_cs = 1'b1;
        step   = 1'b1;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Folded address: when x0's bit is set the other three bits are inverted and the word negated.
  always_comb begin
    plane_addr = {sr1_q[0], sr2_q[0], sr3_q[0]};
    if (sr0_q[0]) plane_addr = ~plane_addr;
    rom_addr = rom_cs ? plane_addr : 3'd0;
  end

  always_comb begin
    rom_word = {rom_data[15], rom_data};
    term     = sr0_q[0] ? -rom_word : rom_word;
    term_ext = {{(ACCW-17){term[16]}}, term};
    term_sh  = term_ext <<< j_q;
    // The sign plane carries negative weight.
    acc_next = last ? (acc_q - term_sh) : (acc_q + term_sh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr0_q <= '0;
      sr1_q <= '0;
      sr2_q <= '0;
      sr3_q <= '0;
      j_q   <= '0;
      acc_q <= '0;
      z_q   <= '0;
    end else if (load) begin
      sr0_q <= x0;
      sr1_q <= x1;
      sr2_q <= x2;
      sr3_q <= x3;
      j_q   <= '0;
      acc_q <= Q0;
    end else if (step) begin
      sr0_q <= sr0_q >> 1;
      sr1_q <= sr1_q >> 1;
      sr2_q <= sr2_q >> 1;
      sr3_q <= sr3_q >> 1;
      j_q   <= j_q + JW'(1);
      acc_q <= acc_next;
      if (last) z_q <= acc_next;
    end
  end

  assign z         = z_q;
  assign dbg_state = state_q;

endmodule
